// File: rtl/seq_det_pkg.sv
// seq_det_pkg: mode encodings and sequence-length limits shared by the detector
package seq_det_pkg;
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_EQU  = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;
endpackage

// File: rtl/seq_det_hit_cnt.sv
// seq_det_hit_cnt: saturating hit counter with a clear that overrides increments
module seq_det_hit_cnt #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);
  logic [CW-1:0] r_cnt;
  // count hits, hold at all-ones, clear or reset wins over increment
  always_ff @(posedge i_clk)
    r_cnt <= (i_rst || i_clr) ? '0 : (i_inc && r_cnt != '1) ? r_cnt + CW'(1) : r_cnt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/seq_detector_gen2.sv
// seq_detector_gen2: detects DEPTH-long arithmetic/equal runs using only the last sample and a run length
module seq_detector_gen2
  import seq_det_pkg::*;
#(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          SYSCLK,
  input  logic          RST,
  input  logic          IN_VALID,
  input  logic [1:0]    MODE,
  input  logic [DW-1:0] STEP,
  input  logic [DW-1:0] DATA_IN,
  input  logic          CLR_CNT,
  output logic          OUT_VALID,
  output logic [DW-1:0] DATA_OUT,
  output logic [CW-1:0] HIT_CNT
);
  localparam int RW = $clog2(DEPTH + 1);
  logic [RW-1:0] r_run, w_run_nx;
  logic [DW-1:0] r_last, r_step_q, r_data_out, w_rise, w_fall;
  logic [1:0]    r_mode_q;
  logic          r_out_valid, w_acc, w_rel, w_restart, w_hit;
  // evaluate the relation against LAST and derive the next run length
  always_comb begin
    w_acc     = IN_VALID && MODE != MODE_IDLE;
    w_rise    = r_last + STEP;
    w_fall    = r_last - STEP;
    w_rel     = MODE == MODE_EQU ? DATA_IN == r_last : MODE == MODE_RISE ? DATA_IN == w_rise : DATA_IN == w_fall;
    w_restart = r_run == '0 || MODE != r_mode_q || (MODE != MODE_EQU && STEP != r_step_q);
    w_run_nx  = (w_restart || !w_rel) ? RW'(1) : r_run == RW'(DEPTH) ? r_run : r_run + RW'(1);
    w_hit     = w_acc && w_run_nx == RW'(DEPTH);
  end
  // tracking state moves only on accepted samples; the hit pulse is registered every cycle
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      r_run       <= '0;
      r_last      <= '0;
      r_mode_q    <= MODE_IDLE;
      r_step_q    <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if (w_acc) begin
        r_run    <= w_run_nx;
        r_last   <= DATA_IN;
        r_mode_q <= MODE;
        r_step_q <= STEP;
      end
      r_out_valid <= w_hit;
      r_data_out  <= w_hit ? DATA_IN : '0;
    end
  end
  seq_det_hit_cnt #(.CW(CW)) u_hit_cnt (
    .i_clk (SYSCLK),
    .i_rst (RST),
    .i_clr (CLR_CNT),
    .i_inc (w_hit),
    .o_cnt (HIT_CNT)
  );
  assign OUT_VALID = r_out_valid;
  assign DATA_OUT  = r_data_out;
endmodule

// File: tb/tb_seq_detector_gen2.sv
// tb_seq_detector_gen2: scoreboard bench with a history-window reference model
module tb_seq_detector_gen2;
  localparam int DEPTH = 4;
  logic SYSCLK = 1'b0;
  logic RST, IN_VALID, CLR_CNT;
  logic [1:0] MODE;
  logic [3:0] STEP, DATA_IN, dout, dout2;
  logic ov, ov2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  typedef struct packed {logic v; logic [3:0] d;} exp_t;
  exp_t sb[$];
  logic [3:0] seg[$];
  logic [1:0] seg_m;
  logic [3:0] seg_s;
  int e8, e2;
  int n_cmp = 0, n_bad = 0;

  always #5 SYSCLK = ~SYSCLK;

  seq_detector_gen2 #(.DW(4), .DEPTH(DEPTH), .CW(8)) dut (
    .SYSCLK(SYSCLK), .RST(RST), .IN_VALID(IN_VALID), .MODE(MODE), .STEP(STEP),
    .DATA_IN(DATA_IN), .CLR_CNT(CLR_CNT), .OUT_VALID(ov), .DATA_OUT(dout), .HIT_CNT(cnt)
  );
  seq_detector_gen2 #(.DW(4), .DEPTH(DEPTH), .CW(2)) dut2 (
    .SYSCLK(SYSCLK), .RST(RST), .IN_VALID(IN_VALID), .MODE(MODE), .STEP(STEP),
    .DATA_IN(DATA_IN), .CLR_CNT(CLR_CNT), .OUT_VALID(ov2), .DATA_OUT(dout2), .HIT_CNT(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit rel(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m, input logic [3:0] s);
    logic [3:0] up, dn;
    up = a + s;
    dn = a - s;
    return m == 2'b10 ? b == a : m == 2'b00 ? b == up : b == dn;
  endfunction

  task automatic compare();
    exp_t it;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      it = sb.pop_front();
      check("out_valid", ov, it.v);
      check("data_out", dout, it.d);
      check("out_valid_cw2", ov2, it.v);
      check("hit_cnt", cnt, e8);
      check("hit_cnt_cw2", cnt2, e2);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] m, input logic [3:0] s, input logic [3:0] d, input logic clr);
    bit hit;
    RST = 0; IN_VALID = v; MODE = m; STEP = s; DATA_IN = d; CLR_CNT = clr;
    hit = 0;
    if (v && m != 2'b11) begin
      if (seg.size() > 0 && (m != seg_m || (m != 2'b10 && s != seg_s))) seg.delete();
      seg.push_back(d);
      if (seg.size() > DEPTH) void'(seg.pop_front());
      seg_m = m;
      seg_s = s;
      if (seg.size() == DEPTH) begin
        hit = 1;
        for (int k = 1; k < DEPTH; k++) if (!rel(seg[k-1], seg[k], m, s)) hit = 0;
      end
    end
    sb.push_back('{hit, hit ? d : 4'd0});
    e8 = clr ? 0 : (hit && e8 != 255) ? e8 + 1 : e8;
    e2 = clr ? 0 : (hit && e2 != 3) ? e2 + 1 : e2;
    @(posedge SYSCLK);
    #1;
    compare();
  endtask

  task automatic rst_cyc();
    RST = 1; IN_VALID = 1; MODE = 2'b00; STEP = 4'd1; DATA_IN = 4'd5; CLR_CNT = 0;
    seg.delete();
    e8 = 0;
    e2 = 0;
    sb.push_back('{1'b0, 4'd0});
    @(posedge SYSCLK);
    #1;
    compare();
  endtask

  task automatic seq(input logic [1:0] m, input logic [3:0] s, input logic [3:0] d);
    cyc(1, m, s, d, 0);
  endtask

  initial begin
    RST = 1; IN_VALID = 0; MODE = 2'b11; STEP = 0; DATA_IN = 0; CLR_CNT = 0;
    e8 = 0; e2 = 0; seg_m = 2'b11; seg_s = 0;
    rst_cyc();
    rst_cyc();
    foreach (seq_a[i]) begin end
    seq(0, 1, 3); seq(0, 1, 4); seq(0, 1, 5); seq(0, 1, 6);
    check("r031_first", {ov, dout}, {1'b1, 4'd6});
    seq(0, 1, 7);
    check("r031_second", {ov, dout}, {1'b1, 4'd7});
    check("r031_cnt", cnt, 2);
    rst_cyc();
    seq(1, 2, 4); seq(1, 2, 2); seq(1, 2, 0); seq(1, 2, 14);
    check("r032_wrap", {ov, dout}, {1'b1, 4'd14});
    rst_cyc();
    seq(0, 1, 1); seq(0, 1, 2); seq(0, 1, 3);
    seq(2, 1, 4); seq(2, 1, 4); seq(2, 1, 4);
    check("r033_nohit", ov, 0);
    seq(2, 1, 4);
    check("r033_hit", {ov, dout}, {1'b1, 4'd4});
    rst_cyc();
    seq(2, 0, 5); seq(2, 3, 5); seq(2, 7, 5); seq(2, 9, 5);
    check("r034_hit", {ov, dout}, {1'b1, 4'd5});
    rst_cyc();
    seq(0, 1, 5); cyc(0, 0, 1, 12, 0); seq(0, 1, 6); seq(3, 1, 9);
    check("r035_idle", ov, 0);
    seq(0, 1, 7); seq(0, 1, 8);
    check("r035_hit", {ov, dout}, {1'b1, 4'd8});
    rst_cyc();
    for (int i = 0; i < 8; i++) seq(2, 0, 1);
    check("r036_sat", cnt2, 3);
    cyc(1, 2, 0, 1, 1);
    check("r036_clr_hit", {ov2, cnt2}, {1'b1, 2'd0});
    rst_cyc();
    seq(0, 1, 1); seq(0, 1, 2); seq(0, 1, 3);
    rst_cyc();
    seq(0, 1, 4);
    check("r037_zero", {ov, dout, cnt}, 13'd0);
    seq(0, 1, 5); seq(0, 1, 6); seq(0, 1, 7);
    check("r038_hit", {ov, dout}, {1'b1, 4'd7});
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) rst_cyc();
      else cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 1)),
               4'($urandom_range(0, 3)), 1'($urandom_range(0, 30) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  int seq_a[0:0];
endmodule

// File: doc/seq_detector_gen2.md
SEQ_DETECTOR_GEN2 -- requirements
Module: seq_detector_gen2

Interface
REQ-001 Parameter DW, default 4: data width in bits, DW >= 2.
REQ-002 Parameter DEPTH, default 4: length of the sequence to detect, range 2..16.
REQ-003 Parameter CW, default 8: width of the hit counter.
REQ-004 SYSCLK  in  1  the single clock; all logic SHALL be rising-edge triggered on it.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 IN_VALID  in  1  sample strobe.
REQ-007 MODE  in  2  00 rising, 01 falling, 10 equal, 11 idle.
REQ-008 STEP  in  DW  increment magnitude for rising and falling modes.
REQ-009 DATA_IN  in  DW  input sample.
REQ-010 CLR_CNT  in  1  synchronous clear of HIT_CNT.
REQ-011 OUT_VALID  out  1  registered one-cycle detection pulse.
REQ-012 DATA_OUT  out  DW  sample that completed the sequence, 0 when OUT_VALID=0.
REQ-013 HIT_CNT  out  CW  saturating count of detections.

Function
REQ-014 A sample SHALL be accepted only when IN_VALID=1 and MODE!=11; otherwise all tracking state SHALL hold.
REQ-015 State: LAST (DW), MODE_Q (2), STEP_Q (DW), RUN (0..DEPTH); each accepted sample SHALL load LAST<=DATA_IN, MODE_Q<=MODE, STEP_Q<=STEP.
REQ-016 Relation: rising means DATA_IN == LAST+STEP mod 2^DW; falling means DATA_IN == LAST-STEP mod 2^DW; equal means DATA_IN == LAST, with STEP ignored.
REQ-017 Restart: on an accepted sample, RUN<=1 if RUN=0, MODE!=MODE_Q, or (MODE in {00,01} and STEP!=STEP_Q).
REQ-018 Continue: otherwise RUN<=min(RUN+1, DEPTH) if the relation holds, else RUN<=1.
REQ-019 Hit: an accepted sample whose next RUN equals DEPTH SHALL produce OUT_VALID=1 and DATA_OUT=DATA_IN on the following cycle; latency is exactly 1 cycle.
REQ-020 Overlapping detection: while RUN stays saturated at DEPTH, every further conforming sample SHALL produce another hit.
REQ-021 OUT_VALID SHALL be 0 in any cycle not following a hit, including cycles after non-accepted samples; DATA_OUT SHALL be 0 whenever OUT_VALID=0.
REQ-022 STEP=0 in rising or falling mode SHALL behave as equal detection; this is legal.
REQ-023 HIT_CNT SHALL increment on every hit and saturate at 2^CW-1.
REQ-024 When CLR_CNT=1, HIT_CNT SHALL become 0 and a simultaneous increment SHALL be discarded; the clear has priority.

Reset
REQ-025 RST=1 at a clock edge SHALL set RUN=0, LAST=0, MODE_Q=11, STEP_Q=0, OUT_VALID=0, DATA_OUT=0 and HIT_CNT=0.
REQ-026 RST SHALL take priority over every input.
REQ-027 Reset mid-sequence SHALL abort the run; the first accepted sample after reset starts with RUN=1.

Structure
REQ-028 Package seq_det_pkg SHALL hold the mode constants MODE_RISE=00, MODE_FALL=01, MODE_EQU=10, MODE_IDLE=11 and the DEPTH range limits.
REQ-029 The saturating, clearable hit counter SHALL be the sub-module seq_det_hit_cnt, parametrised by CW.
REQ-030 RTL SHALL NOT store the full sample history; detection SHALL use LAST and RUN only.

Verification (DW=4, DEPTH=4, CW=8 unless stated)
REQ-031 MODE=00, STEP=1, samples 3,4,5,6,7 -> a pulse with DATA_OUT=6 one cycle after 6, a second pulse with DATA_OUT=7, and HIT_CNT=2.
REQ-032 MODE=01, STEP=2, samples 4,2,0,14 -> a pulse with DATA_OUT=14, covering wrap-around.
REQ-033 Samples 1,2,3 at MODE=00, then 4,4,4,4 at MODE=10 -> no pulse through the first three 4s, and a pulse with DATA_OUT=4 after the fourth 4.
REQ-034 MODE=10 with samples 5,5,5,5 and STEP changing every sample -> a pulse with DATA_OUT=5, since STEP is ignored in equal mode.
REQ-035 MODE=00, STEP=1, samples 5, idle gap, 6, a MODE=11 sample 9, then 7, 8 -> a pulse with DATA_OUT=8; the gap and the 9 are ignored.
REQ-036 CW=2: 5 hits give HIT_CNT=3; CLR_CNT coincident with a hit gives HIT_CNT=0.
REQ-037 Samples 1,2,3, then RST for one cycle, then 4 -> no pulse and all outputs 0.
REQ-038 Rising samples 4,5,6,7 after that reset -> a pulse with DATA_OUT=7.
